tmem_bank_scheduler: RTL and testbench



---
 rtl/tmem_bank_scheduler_pkg.sv | 14 +
 rtl/tmem_bank_scheduler_rr_pick.sv | 34 +++
 rtl/tmem_bank_scheduler.sv | 139 +++++++++++++
 tb/tb_tmem_bank_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmem_bank_scheduler_pkg.sv
// Shared defaults and state encoding for the TMEM per-bank read scheduler.
package tmem_bank_scheduler_pkg;

   localparam int NUM_CORES_DEF = 4;
   localparam int CORE_BITS_DEF = 2;
   localparam int ADDR_W_DEF    = 32;
   localparam int HOLD_W        = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } sched_state_e;

endpackage

// File: rtl/tmem_bank_scheduler_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after start, with wrap.
module tmem_bank_scheduler_rr_pick
   import tmem_bank_scheduler_pkg::*;
#(
   parameter int NUM_CORES = NUM_CORES_DEF,
   parameter int CORE_BITS = CORE_BITS_DEF
)(
   input  logic [NUM_CORES-1:0] req,
   input  logic [CORE_BITS-1:0] start,
   input  logic [NUM_CORES-1:0] excl,
   output logic                 found,
   output logic [CORE_BITS-1:0] winner
);

   logic [NUM_CORES-1:0] elig;
   logic [CORE_BITS-1:0] idx;

   // Scan from the farthest offset back to the nearest so the nearest hit wins;
   // CORE_BITS-wide addition gives the wrap for free.
   always_comb begin
      elig   = req & ~excl;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         idx = start + CORE_BITS'(i);
         if (elig[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/tmem_bank_scheduler.sv
// Per-bank TMEM read scheduler: round-robin ownership of the bank read port with a
// hold limit, virtual-to-bank address translation and a latency-aligned data-valid strobe.
//
// state | meaning
// IDLE  | no owner; any request wins a grant at the next edge
// OWN   | core sel_q owns the read port; hold_q counts down to a forced handoff
module tmem_bank_scheduler
   import tmem_bank_scheduler_pkg::*;
#(
   parameter int NUM_CORES = NUM_CORES_DEF,
   parameter int CORE_BITS = CORE_BITS_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MAX_HOLD  = 8,
   parameter int RD_LAT    = 1
)(
   input  logic                        CLK_I,
   input  logic                        RST_I,
   input  logic [NUM_CORES-1:0]        REQ_I,
   input  logic [NUM_CORES*ADDR_W-1:0] ADR_I,
   output logic [NUM_CORES-1:0]        GNT_O,
   output logic [CORE_BITS-1:0]        SEL_O,
   output logic                        BANK_RD_O,
   output logic [ADDR_W-1:0]           BANK_ADR_O,
   output logic [NUM_CORES-1:0]        DVLD_O,
   output logic                        BUSY_O
);

   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MAX_HOLD - 1);

   sched_state_e         state_q, state_d;
   logic [NUM_CORES-1:0] gnt_q, gnt_d;
   logic [CORE_BITS-1:0] sel_q, sel_d;
   logic [CORE_BITS-1:0] last_q, last_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic [NUM_CORES-1:0] dvld_q [RD_LAT];

   logic [ADDR_W-1:0]    adr_core [NUM_CORES];
   logic [CORE_BITS-1:0] pick_start;
   logic [NUM_CORES-1:0] pick_excl;
   logic                 pick_found;
   logic [CORE_BITS-1:0] pick_idx;
   logic                 busy;
   logic                 own_req;
   logic                 others_req;
   logic                 bank_rd;

   tmem_bank_scheduler_rr_pick #(
      .NUM_CORES (NUM_CORES),
      .CORE_BITS (CORE_BITS)
   ) u_rr_pick (
      .req    (REQ_I),
      .start  (pick_start),
      .excl   (pick_excl),
      .found  (pick_found),
      .winner (pick_idx)
   );

   always_comb begin
      for (int k = 0; k < NUM_CORES; k++) begin
         adr_core[k] = ADR_I[k*ADDR_W +: ADDR_W];
      end
      busy       = (state_q == ST_OWN);
      own_req    = REQ_I[sel_q];
      others_req = |(REQ_I & ~gnt_q);
      bank_rd    = busy & own_req & gnt_q[sel_q];
      // The owner is always excluded so an expiring core cannot re-win its own handoff.
      if (busy) begin
         pick_start = sel_q + CORE_BITS'(1);
         pick_excl  = gnt_q;
      end else begin
         pick_start = last_q + CORE_BITS'(1);
         pick_excl  = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      hold_d  = hold_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_OWN;
               gnt_d   = {{(NUM_CORES-1){1'b0}}, 1'b1} << pick_idx;
               sel_d   = pick_idx;
               hold_d  = HOLD_LOAD;
            end
         end
         ST_OWN: begin
            if (!own_req || (hold_q == '0 && others_req)) begin
               last_d = sel_q;
               if (pick_found) begin
                  gnt_d  = {{(NUM_CORES-1){1'b0}}, 1'b1} << pick_idx;
                  sel_d  = pick_idx;
                  hold_d = HOLD_LOAD;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end else if (hold_q != '0) begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= CORE_BITS'(NUM_CORES - 1);
         hold_q  <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            dvld_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         sel_q     <= sel_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         dvld_q[0] <= bank_rd ? gnt_q : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            dvld_q[i] <= dvld_q[i-1];
         end
      end
   end

   assign GNT_O      = gnt_q;
   assign SEL_O      = sel_q;
   assign BUSY_O     = busy;
   assign BANK_RD_O  = bank_rd;
   assign BANK_ADR_O = busy ? (adr_core[sel_q] >> CORE_BITS) : '0;
   assign DVLD_O     = dvld_q[RD_LAT-1];

endmodule

// File: tb/tb_tmem_bank_scheduler.sv
// Bench for tmem_bank_scheduler: two instances (read latency 1 and 3) share one stimulus stream.
module tb_tmem_bank_scheduler;

   localparam int NC    = 4;
   localparam int CB    = 2;
   localparam int AW    = 32;
   localparam int MH    = 4;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam int BOUND = (NC - 1) * MH + NC;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NC-1:0]   req = '0;
   logic [NC*AW-1:0] adr = '0;

   logic [NC-1:0] a_gnt, b_gnt, a_dvld, b_dvld;
   logic [CB-1:0] a_sel, b_sel;
   logic          a_rd, b_rd, a_busy, b_busy;
   logic [AW-1:0] a_badr, b_badr;

   tmem_bank_scheduler #(.NUM_CORES(NC), .CORE_BITS(CB), .ADDR_W(AW), .MAX_HOLD(MH), .RD_LAT(LAT_A)) dut_a (
      .CLK_I(clk), .RST_I(rst_n), .REQ_I(req), .ADR_I(adr), .GNT_O(a_gnt), .SEL_O(a_sel),
      .BANK_RD_O(a_rd), .BANK_ADR_O(a_badr), .DVLD_O(a_dvld), .BUSY_O(a_busy));

   tmem_bank_scheduler #(.NUM_CORES(NC), .CORE_BITS(CB), .ADDR_W(AW), .MAX_HOLD(MH), .RD_LAT(LAT_B)) dut_b (
      .CLK_I(clk), .RST_I(rst_n), .REQ_I(req), .ADR_I(adr), .GNT_O(b_gnt), .SEL_O(b_sel),
      .BANK_RD_O(b_rd), .BANK_ADR_O(b_badr), .DVLD_O(b_dvld), .BUSY_O(b_busy));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [NC-1:0] gnt;
      logic [CB-1:0] sel;
      logic          busy;
      logic          rd;
      logic [AW-1:0] badr;
   } exp_t;

   typedef struct {
      int            due;
      logic [NC-1:0] mask;
   } dv_t;

   exp_t exp_q[$];
   dv_t  dva_q[$];
   dv_t  dvb_q[$];

   bit m_own;
   int m_owner, m_last, m_cnt;

   function automatic int pick(input logic [NC-1:0] r, input int start, input logic [NC-1:0] excl);
      for (int i = 0; i < NC; i++) begin
         int k;
         k = (start + i) % NC;
         if (r[k] && !excl[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_own = 1'b0;
      m_owner = 0;
      m_last = NC - 1;
      m_cnt = 0;
      exp_q.delete();
      dva_q.delete();
      dvb_q.delete();
   endtask

   task automatic tick(input logic [NC-1:0] r, input logic [NC*AW-1:0] a);
      exp_t          e;
      dv_t           d;
      logic [NC-1:0] oh;
      int            w;
      @(negedge clk);
      req = r;
      adr = a;
      #1;
      oh     = m_own ? NC'(1 << m_owner) : '0;
      e.gnt  = oh;
      e.sel  = m_own ? CB'(m_owner) : '0;
      e.busy = m_own;
      e.rd   = m_own && r[m_owner];
      e.badr = m_own ? (a[m_owner*AW +: AW] >> CB) : '0;
      exp_q.push_back(e);
      if (e.rd) begin
         d.mask = oh;
         d.due = cyc + LAT_A;
         dva_q.push_back(d);
         d.due = cyc + LAT_B;
         dvb_q.push_back(d);
      end
      if (!m_own) begin
         w = pick(r, (m_last + 1) % NC, '0);
         if (w >= 0) begin
            m_own = 1'b1;
            m_owner = w;
            m_cnt = 0;
         end
      end else if (!r[m_owner]) begin
         m_last = m_owner;
         w = pick(r, (m_owner + 1) % NC, oh);
         if (w >= 0) begin
            m_owner = w;
            m_cnt = 0;
         end else begin
            m_own = 1'b0;
         end
      end else if (m_cnt == MH - 1 && (r & ~oh) != '0) begin
         m_last = m_owner;
         m_owner = pick(r, (m_owner + 1) % NC, oh);
         m_cnt = 0;
      end else if (m_cnt < MH - 1) begin
         m_cnt++;
      end
   endtask

   function automatic logic [NC*AW-1:0] rand_adr();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Scoreboard: pops one expectation per driven cycle; DVLD expectations are due-cycle tagged.
   always @(negedge clk) begin : mon
      exp_t          e;
      dv_t           d;
      logic [NC-1:0] xa, xb;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         xa = '0;
         xb = '0;
         if (dva_q.size() > 0 && dva_q[0].due == cyc) begin d = dva_q.pop_front(); xa = d.mask; end
         if (dvb_q.size() > 0 && dvb_q[0].due == cyc) begin d = dvb_q.pop_front(); xb = d.mask; end
         n_cmp++;
         if ({a_gnt, a_busy, a_rd, a_badr} !== {e.gnt, e.busy, e.rd, e.badr}) begin
            n_bad++;
            $display("FAIL sb_ctl_a cyc=%0d got gnt=%b busy=%b rd=%b adr=%h exp gnt=%b busy=%b rd=%b adr=%h",
                     cyc, a_gnt, a_busy, a_rd, a_badr, e.gnt, e.busy, e.rd, e.badr);
         end
         n_cmp++;
         if ({b_gnt, b_busy, b_rd, b_badr} !== {e.gnt, e.busy, e.rd, e.badr}) begin
            n_bad++;
            $display("FAIL sb_ctl_b cyc=%0d got gnt=%b busy=%b rd=%b adr=%h exp gnt=%b busy=%b rd=%b adr=%h",
                     cyc, b_gnt, b_busy, b_rd, b_badr, e.gnt, e.busy, e.rd, e.badr);
         end
         if (e.busy) begin
            n_cmp++;
            if (a_sel !== e.sel || b_sel !== e.sel) begin
               n_bad++;
               $display("FAIL sb_sel cyc=%0d got a=%0d b=%0d exp=%0d", cyc, a_sel, b_sel, e.sel);
            end
         end
         n_cmp++;
         if (a_dvld !== xa) begin
            n_bad++;
            $display("FAIL sb_dvld_a cyc=%0d got=%b exp=%b", cyc, a_dvld, xa);
         end
         n_cmp++;
         if (b_dvld !== xb) begin
            n_bad++;
            $display("FAIL sb_dvld_b cyc=%0d got=%b exp=%b", cyc, b_dvld, xb);
         end
      end
   end

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      adr = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({a_gnt, a_sel, a_busy, a_rd, a_badr, a_dvld} !== '0) begin
         n_bad++;
         $display("FAIL reset_a got gnt=%b sel=%0d busy=%b rd=%b adr=%h dvld=%b exp all zero",
                  a_gnt, a_sel, a_busy, a_rd, a_badr, a_dvld);
      end
      n_cmp++;
      if ({b_gnt, b_sel, b_busy, b_rd, b_badr, b_dvld} !== '0) begin
         n_bad++;
         $display("FAIL reset_b got gnt=%b sel=%0d busy=%b rd=%b adr=%h dvld=%b exp all zero",
                  b_gnt, b_sel, b_busy, b_rd, b_badr, b_dvld);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [NC*AW-1:0] a;
      reset_dut();
      a = '0;
      a[AW-1:0] = 32'h104;
      tick(4'b0001, a);
      tick(4'b0001, a);
      n_cmp++;
      if (a_gnt !== 4'b0001 || a_rd !== 1'b1 || a_badr !== 32'h41) begin
         n_bad++;
         $display("FAIL single_grant got gnt=%b rd=%b adr=%h exp gnt=0001 rd=1 adr=41", a_gnt, a_rd, a_badr);
      end
      tick(4'b0000, a);
      n_cmp++;
      if (a_dvld !== 4'b0001) begin
         n_bad++;
         $display("FAIL single_dvld got=%b exp=0001", a_dvld);
      end
      repeat (3) tick(4'b0000, a);
   endtask

   task automatic test_contention();
      logic [NC-1:0] g [13];
      logic [NC-1:0] x;
      reset_dut();
      for (int c = 0; c < 13; c++) begin
         tick(4'b0101, rand_adr());
         g[c] = a_gnt;
      end
      for (int c = 1; c < 13; c++) begin
         x = (c >= 5 && c <= 8) ? 4'b0100 : 4'b0001;
         n_cmp++;
         if (g[c] !== x) begin
            n_bad++;
            $display("FAIL contention cyc%0d got=%b exp=%b", c, g[c], x);
         end
      end
   endtask

   task automatic test_release();
      reset_dut();
      tick(4'b0010, rand_adr());
      tick(4'b1010, rand_adr());
      n_cmp++;
      if (a_gnt !== 4'b0010) begin
         n_bad++;
         $display("FAIL release_owner got=%b exp=0010", a_gnt);
      end
      tick(4'b1000, rand_adr());
      tick(4'b1000, rand_adr());
      n_cmp++;
      if (a_gnt !== 4'b1000 || a_sel !== 2'd3 || a_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL release_handoff got gnt=%b sel=%0d busy=%b exp gnt=1000 sel=3 busy=1", a_gnt, a_sel, a_busy);
      end
   endtask

   task automatic test_no_contention();
      reset_dut();
      tick(4'b0010, rand_adr());
      for (int c = 1; c <= 20; c++) begin
         tick(4'b0010, rand_adr());
         n_cmp++;
         if (a_gnt !== 4'b0010 || a_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL no_contention cyc%0d got gnt=%b rd=%b exp gnt=0010 rd=1", c, a_gnt, a_rd);
         end
      end
   endtask

   task automatic test_latency();
      logic [NC-1:0] da [10];
      logic [NC-1:0] db [10];
      logic [NC-1:0] g5;
      reset_dut();
      g5 = '0;
      for (int c = 0; c < 10; c++) begin
         tick((c >= 1 && c <= 4) ? 4'b1100 : (c == 0 ? 4'b0100 : 4'b1000), rand_adr());
         da[c] = a_dvld;
         db[c] = b_dvld;
         if (c == 5) g5 = a_gnt;
      end
      n_cmp++;
      if (g5 !== 4'b1000) begin
         n_bad++;
         $display("FAIL lat_handoff got=%b exp=1000", g5);
      end
      n_cmp++;
      if (db[7] !== 4'b0100 || db[8] !== 4'b1000) begin
         n_bad++;
         $display("FAIL lat3_dvld got t+3=%b t+4=%b exp 0100 1000", db[7], db[8]);
      end
      n_cmp++;
      if (da[5] !== 4'b0100 || da[6] !== 4'b1000) begin
         n_bad++;
         $display("FAIL lat1_dvld got t+1=%b t+2=%b exp 0100 1000", da[5], da[6]);
      end
   endtask

   task automatic test_reset_midop();
      logic [NC-1:0] g5;
      reset_dut();
      tick(4'b1000, rand_adr());
      tick(4'b1000, rand_adr());
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         #1;
         n_cmp++;
         if ({a_gnt, a_busy, a_rd, a_badr, a_dvld, b_gnt, b_busy, b_rd, b_badr, b_dvld, a_sel, b_sel} !== '0) begin
            n_bad++;
            $display("FAIL midop_reset%0d got a gnt=%b dvld=%b b gnt=%b dvld=%b busy=%b%b exp all zero",
                     k, a_gnt, a_dvld, b_gnt, b_dvld, a_busy, b_busy);
         end
         @(negedge clk);
      end
      rst_n = 1'b1;
      g5 = '0;
      tick(4'b1001, rand_adr());
      tick(4'b1001, rand_adr());
      n_cmp++;
      if (a_gnt !== 4'b0001 || a_sel !== 2'd0) begin
         n_bad++;
         $display("FAIL midop_first got gnt=%b sel=%0d exp gnt=0001 sel=0", a_gnt, a_sel);
      end
      for (int c = 2; c <= 5; c++) begin
         tick(4'b1001, rand_adr());
         if (c == 5) g5 = a_gnt;
      end
      n_cmp++;
      if (g5 !== 4'b1000) begin
         n_bad++;
         $display("FAIL midop_rr got=%b exp=1000", g5);
      end
      repeat (4) tick(4'b0000, rand_adr());
   endtask

   task automatic test_random();
      logic [NC-1:0] r;
      int            wait_c [NC];
      reset_dut();
      r = '0;
      for (int k = 0; k < NC; k++) wait_c[k] = 0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) r = NC'($urandom_range(0, 15));
         tick(r, rand_adr());
         n_cmp++;
         if (!$onehot0(a_gnt) || !$onehot0(b_dvld) || !$onehot0(a_dvld) || (a_rd && !a_busy)) begin
            n_bad++;
            $display("FAIL invariant cyc=%0d got gnt=%b dvld_a=%b dvld_b=%b rd=%b busy=%b", c, a_gnt, a_dvld, b_dvld, a_rd, a_busy);
         end
         for (int k = 0; k < NC; k++) begin
            wait_c[k] = (r[k] && !a_gnt[k]) ? wait_c[k] + 1 : 0;
            if (wait_c[k] > BOUND) begin
               n_cmp++;
               n_bad++;
               $display("FAIL starvation core%0d got wait=%0d exp<=%0d", k, wait_c[k], BOUND);
               wait_c[k] = 0;
            end
         end
      end
      repeat (4) tick(4'b0000, rand_adr());
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_release();
      test_no_contention();
      test_latency();
      test_reset_midop();
      test_random();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
